// File: rtl/goldminer_pkg.sv
// Shared types and constants for the double SHA-256 nonce scheduler:
// FSM states, host register map, padding words and the hash compare helper.
package goldminer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_LOAD,
    ST_FIRE,
    ST_ARM,
    ST_WAIT,
    ST_CHECK,
    ST_NEXT
  } state_t;

  localparam logic [5:0] ADDR_HEADER_LAST = 6'h12;
  localparam logic [5:0] ADDR_NONCE_START = 6'h13;
  localparam logic [5:0] ADDR_NONCE_END   = 6'h14;
  localparam logic [5:0] ADDR_CTRL        = 6'h20;
  localparam logic [5:0] ADDR_STATUS      = 6'h21;
  localparam logic [5:0] ADDR_FOUND_NONCE = 6'h22;
  localparam logic [5:0] ADDR_NONCE       = 6'h23;

  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam logic [31:0] LEN_HEADER = 32'h0000_0280;
  localparam logic [31:0] LEN_DIGEST = 32'h0000_0100;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Byte-swapped mode reverses the whole digest so it reads as the usual
  // big-number hash: bswap(h7) lands in the most significant word.
  function automatic logic [255:0] hash_value(input logic [255:0] digest,
                                              input logic        bswap_en);
    logic [255:0] v;
    v = digest;
    if (bswap_en) begin
      for (int i = 0; i < 8; i++) begin
        v[32*i +: 32] = bswap32(digest[255-32*i -: 32]);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sha256_block_mux.sv
// Selects the 32-bit message word fed to the SHA-256 core for the current
// pass (header block, header tail + nonce, or first-hash digest) and word index.
module sha256_block_mux
  import goldminer_pkg::*;
#(
  parameter bit NONCE_BSWAP = 1'b1
) (
  input  logic [1:0]        pass,
  input  logic [3:0]        word_idx,
  input  logic [18:0][31:0] header,
  input  logic [31:0]       nonce,
  input  logic [255:0]      digest,
  output logic [31:0]       wdata
);

  logic [31:0] nonce_word;
  logic [2:0]  digest_sel;

  assign nonce_word = NONCE_BSWAP ? bswap32(nonce) : nonce;
  assign digest_sel = 3'd7 - word_idx[2:0];

  always_comb begin
    wdata = '0;
    case (pass)
      2'd0: wdata = header[{1'b0, word_idx}];
      2'd1: begin
        case (word_idx)
          4'd0:    wdata = header[16];
          4'd1:    wdata = header[17];
          4'd2:    wdata = header[18];
          4'd3:    wdata = nonce_word;
          4'd4:    wdata = PAD_WORD;
          4'd15:   wdata = LEN_HEADER;
          default: wdata = '0;
        endcase
      end
      2'd2: begin
        if (word_idx < 4'd8) begin
          wdata = digest[{digest_sel, 5'd0} +: 32];
        end else if (word_idx == 4'd8) begin
          wdata = PAD_WORD;
        end else if (word_idx == 4'd15) begin
          wdata = LEN_DIGEST;
        end
      end
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// Host-programmed nonce sweep: drives an external SHA-256 core through a
// double hash of an 80-byte header per nonce and compares against a target.
module sha256d_nonce_scheduler
  import goldminer_pkg::*;
#(
  parameter bit NONCE_BSWAP = 1'b1,
  parameter bit HASH_BSWAP  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chipselect,
  input  logic         write,
  input  logic         read,
  input  logic [5:0]   address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         core_rst,
  output logic         core_cs,
  output logic         core_write,
  output logic [3:0]   core_addr,
  output logic [31:0]  core_wdata,
  output logic         core_go,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic         found
);

  state_t state, state_next;

  logic [18:0][31:0] header;
  logic [31:0]       nonce_start;
  logic [31:0]       nonce_end;
  logic [31:0]       nonce;
  logic [31:0]       found_nonce;
  logic [255:0]      target;
  logic [255:0]      digest_q;
  logic [1:0]        pass;
  logic [3:0]        word_idx;
  logic              exhausted;
  logic              rst_pulse;
  logic [31:0]       rd_mux;
  logic [2:0]        target_sel;

  logic host_wr;
  logic cfg_wr;
  logic stop_cmd;
  logic start_cmd;
  logic hit;

  assign host_wr    = chipselect & write;
  assign cfg_wr     = host_wr & (state == ST_IDLE);
  assign stop_cmd   = host_wr & (address == ADDR_CTRL) & writedata[1];
  assign start_cmd  = host_wr & (address == ADDR_CTRL) & writedata[0] &
                      ~writedata[1] & (state == ST_IDLE);
  assign hit        = hash_value(digest_q, HASH_BSWAP) <= target;
  assign target_sel = 3'd7 - address[2:0];

  sha256_block_mux #(
    .NONCE_BSWAP(NONCE_BSWAP)
  ) u_block_mux (
    .pass     (pass),
    .word_idx (word_idx),
    .header   (header),
    .nonce    (nonce),
    .digest   (digest_q),
    .wdata    (core_wdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pass 1 chains from pass 0 without a core reset; pass 2 starts a fresh hash.
  always_comb begin
    state_next = state;
    if (stop_cmd) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_cmd) state_next = ST_CRST;
        ST_CRST:  state_next = ST_LOAD;
        ST_LOAD:  if (word_idx == 4'd15) state_next = ST_FIRE;
        ST_FIRE:  state_next = ST_ARM;
        ST_ARM:   state_next = ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            case (pass)
              2'd0:    state_next = ST_LOAD;
              2'd1:    state_next = ST_CRST;
              default: state_next = ST_CHECK;
            endcase
          end
        end
        ST_CHECK: state_next = hit ? ST_IDLE : ST_NEXT;
        ST_NEXT:  state_next = (nonce == nonce_end) ? ST_IDLE : ST_CRST;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // A stop suppresses any datapath update in the same cycle, so found and
  // exhausted keep whatever value they had before the stop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      header      <= '0;
      nonce_start <= '0;
      nonce_end   <= '0;
      target      <= '0;
      nonce       <= '0;
      found_nonce <= '0;
      digest_q    <= '0;
      pass        <= '0;
      word_idx    <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      rst_pulse   <= 1'b1;
      readdata    <= '0;
    end else begin
      rst_pulse <= stop_cmd;
      word_idx  <= (state == ST_LOAD) ? word_idx + 4'd1 : 4'd0;

      if (cfg_wr) begin
        if (address <= ADDR_HEADER_LAST) begin
          header[address[4:0]] <= writedata;
        end else if (address == ADDR_NONCE_START) begin
          nonce_start <= writedata;
        end else if (address == ADDR_NONCE_END) begin
          nonce_end <= writedata;
        end else if (address[5:3] == 3'b011) begin
          target[{target_sel, 5'd0} +: 32] <= writedata;
        end
      end

      if (!stop_cmd) begin
        case (state)
          ST_IDLE: begin
            if (start_cmd) begin
              nonce     <= nonce_start;
              found     <= 1'b0;
              exhausted <= 1'b0;
              pass      <= 2'd0;
            end
          end
          ST_WAIT: begin
            if (core_done) begin
              if (pass != 2'd0) digest_q <= core_digest;
              if (pass != 2'd2) pass <= pass + 2'd1;
            end
          end
          ST_CHECK: begin
            if (hit) begin
              found       <= 1'b1;
              found_nonce <= nonce;
            end
          end
          ST_NEXT: begin
            if (nonce == nonce_end) begin
              exhausted <= 1'b1;
            end else begin
              nonce <= nonce + 32'd1;
              pass  <= 2'd0;
            end
          end
          default: ;
        endcase
      end

      if (chipselect && read) begin
        readdata <= rd_mux;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (address <= ADDR_HEADER_LAST) begin
      rd_mux = header[address[4:0]];
    end else if (address[5:3] == 3'b011) begin
      rd_mux = target[{target_sel, 5'd0} +: 32];
    end else begin
      case (address)
        ADDR_NONCE_START: rd_mux = nonce_start;
        ADDR_NONCE_END:   rd_mux = nonce_end;
        ADDR_STATUS:      rd_mux = {29'd0, exhausted, found, busy};
        ADDR_FOUND_NONCE: rd_mux = found_nonce;
        ADDR_NONCE:       rd_mux = nonce;
        default:          rd_mux = '0;
      endcase
    end
  end

  // Core reset is held through our own reset and pulsed once after a stop.
  always_comb begin
    core_rst   = rst_pulse | (state == ST_CRST);
    core_cs    = (state == ST_LOAD);
    core_write = (state == ST_LOAD);
    core_addr  = word_idx;
    core_go    = (state == ST_FIRE);
    busy       = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Directed bench: behavioural SHA-256 core model plus Bitcoin genesis-block
// vectors, range/wrap/stop/reset scenarios and a core write/go protocol watcher.
module tb_sha256d_nonce_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         chipselect = 1'b0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [5:0]   address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         core_rst, core_cs, core_write, core_go, busy, found;
  logic [3:0]   core_addr;
  logic [31:0]  core_wdata;
  logic         core_done = 1'b1;
  logic [255:0] core_h;

  int tests = 0;
  int fails = 0;
  int go_count = 0;
  int wr_count = 0;
  int model_lat = 3;
  int model_cnt = 0;
  logic [31:0] rd;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0] genesis [0:18] = '{
    32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};

  logic [15:0][31:0] core_mem = '0;

  sha256d_nonce_scheduler #(.NONCE_BSWAP(1'b1), .HASH_BSWAP(1'b1)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .core_rst(core_rst), .core_cs(core_cs), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_go(core_go),
    .core_done(core_done), .core_digest(core_h), .busy(busy), .found(found));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin,
                                                input logic [15:0][31:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural round core with a programmable completion latency.
  initial core_h = IV;
  always @(posedge clk) begin
    if (core_rst) begin
      core_h    <= IV;
      core_done <= 1'b1;
      model_cnt <= 0;
    end else begin
      if (core_cs && core_write) core_mem[core_addr] <= core_wdata;
      if (core_go) begin
        core_done <= 1'b0;
        model_cnt <= model_lat;
      end else if (!core_done) begin
        if (model_cnt == 0) begin
          core_h    <= sha_compress(core_h, core_mem);
          core_done <= 1'b1;
        end else begin
          model_cnt <= model_cnt - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every go must follow exactly 16 ascending writes and only while busy.
  always @(negedge clk) begin
    if (core_rst) wr_count = 0;
    if (core_cs && core_write) begin
      checkOutput("core_addr order", 64'(core_addr), 64'(wr_count));
      wr_count++;
    end
    if (core_go) begin
      checkOutput("writes before go", 64'(wr_count), 64'd16);
      checkOutput("go while busy", 64'(busy), 64'd1);
      wr_count = 0;
      go_count++;
    end
  end

  task automatic applyStimulus(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic readReg(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic setTarget(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] rest);
    applyStimulus(6'h18, w0);
    applyStimulus(6'h19, w1);
    for (int i = 2; i < 8; i++) applyStimulus(6'(8'h18 + i), rest);
  endtask

  task automatic startRun(input logic [31:0] s, input logic [31:0] e);
    applyStimulus(6'h13, s);
    applyStimulus(6'h14, e);
    go_count = 0;
    applyStimulus(6'h20, 32'h1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] top_val;
    int n;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset found", 64'(found), 64'd0);
    checkOutput("reset core_go", 64'(core_go), 64'd0);
    checkOutput("reset core_cs", 64'({core_cs, core_write}), 64'd0);
    checkOutput("reset readdata", 64'(readdata), 64'd0);
    checkOutput("reset core_rst held", 64'(core_rst), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("core_rst released", 64'(core_rst), 64'd0);

    for (int i = 0; i < 19; i++) applyStimulus(6'(i), genesis[i]);
    readReg(6'h09, rd);
    checkOutput("header readback", 64'(rd), 64'h3ba3edfd);

    // Genesis nonce against the difficulty-1 target
    setTarget(32'h0, 32'hFFFF0000, 32'h0);
    model_lat = 3;
    startRun(32'h7C2BAC1D, 32'h7C2BAC1D);
    waitIdle("genesis idle", 2000);
    checkOutput("genesis found", 64'(found), 64'd1);
    readReg(6'h22, rd);
    checkOutput("genesis found_nonce", 64'(rd), 64'h7C2BAC1D);
    readReg(6'h21, rd);
    checkOutput("genesis status", 64'(rd), 64'h2);
    checkOutput("genesis go count", 64'(go_count), 64'd3);
    top_val = {bswap(core_h[31:0]), bswap(core_h[63:32])};
    checkOutput("genesis hash top", top_val, 64'h000000000019D668);

    // Impossible target over five nonces
    setTarget(32'h0, 32'h0, 32'h0);
    model_lat = 0;
    startRun(32'h7C2BAC1B, 32'h7C2BAC1F);
    waitIdle("range idle", 3000);
    readReg(6'h21, rd);
    checkOutput("range status exhausted", 64'(rd), 64'h4);
    readReg(6'h23, rd);
    checkOutput("range current nonce", 64'(rd), 64'h7C2BAC1F);
    checkOutput("range go count", 64'(go_count), 64'd15);

    // Any hash meets an all-ones target
    setTarget(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    model_lat = 7;
    startRun(32'h10, 32'h20);
    waitIdle("allones idle", 2000);
    checkOutput("allones found", 64'(found), 64'd1);
    readReg(6'h22, rd);
    checkOutput("allones found_nonce", 64'(rd), 64'h10);
    checkOutput("allones go count", 64'(go_count), 64'd3);

    // Wrap through 0xFFFFFFFF; mid-run config write and restart must be ignored
    setTarget(32'h0, 32'h0, 32'h0);
    model_lat = 2;
    startRun(32'hFFFFFFFE, 32'h1);
    applyStimulus(6'h14, 32'hFFFFFFFE);
    applyStimulus(6'h20, 32'h1);
    waitIdle("wrap idle", 4000);
    readReg(6'h21, rd);
    checkOutput("wrap status exhausted", 64'(rd), 64'h4);
    readReg(6'h23, rd);
    checkOutput("wrap current nonce", 64'(rd), 64'h1);
    checkOutput("wrap go count", 64'(go_count), 64'd12);
    readReg(6'h14, rd);
    checkOutput("wrap end unchanged", 64'(rd), 64'h1);

    // Stop while pass 1 is waiting on the core
    model_lat = 8;
    startRun(32'h0, 32'hFFFF);
    n = 0;
    while (go_count < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stop reached pass1", 64'(go_count), 64'd2);
    repeat (2) @(negedge clk);
    applyStimulus(6'h20, 32'h3);
    checkOutput("stop busy", 64'(busy), 64'd0);
    checkOutput("stop core_rst pulse", 64'(core_rst), 64'd1);
    @(negedge clk);
    checkOutput("stop core_rst end", 64'(core_rst), 64'd0);
    readReg(6'h21, rd);
    checkOutput("stop status", 64'(rd), 64'h0);
    checkOutput("stop no extra go", 64'(go_count), 64'd2);

    // Reset asserted while loading words into the core
    startRun(32'h5, 32'h50);
    n = 0;
    while (!core_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached LOAD", 64'(core_cs), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset core_cs", 64'({core_cs, core_write}), 64'd0);
    checkOutput("midreset core_go", 64'(core_go), 64'd0);
    checkOutput("midreset core_rst", 64'(core_rst), 64'd1);
    reset = 1'b1;
    go_count = 0;
    repeat (40) @(negedge clk);
    checkOutput("post reset no go", 64'(go_count), 64'd0);
    checkOutput("post reset busy", 64'(busy), 64'd0);
    readReg(6'h23, rd);
    checkOutput("post reset nonce", 64'(rd), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
